// File: rtl/ring_arb_pkg.sv
// rtl/ring_arb_pkg.sv - state type, default sizes and one-hot helpers for the ring arbiter
package ring_arb_pkg;

   localparam int DEF_N        = 4;
   localparam int DEF_MAX_HOLD = 8;
   localparam int MAX_N        = 16;

   typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_e;

   function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

   // Rotate the low n bits left by one; bits at n and above come back zero.
   function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
      logic [MAX_N-1:0] r;
      r    = {v[MAX_N-2:0], 1'b0};
      r[0] = v[4'(n - 1)];
      if (n < MAX_N) r[4'(n)] = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/rr_ring_pick.sv
// rtl/rr_ring_pick.sv - combinational first-set search from a one-hot start point, wrapping
module rr_ring_pick
   import ring_arb_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [N-1:0]  ptr_i,
   output logic [N-1:0]  win_oh_o,
   output logic [IW-1:0] win_idx_o,
   output logic          any_o
);

   localparam int W2 = 2 * N;

   logic [W2-1:0] dbl;
   logic [W2-1:0] masked;
   logic [W2-1:0] lowest;

   // The upper copy of req supplies the wrapped-around candidates below ptr.
   always_comb begin
      dbl       = {req_i, req_i};
      masked    = dbl & ~({{N{1'b0}}, ptr_i} - W2'(1));
      lowest    = masked & ((~masked) + W2'(1));
      win_oh_o  = lowest[N-1:0] | lowest[W2-1:N];
      win_idx_o = IW'(onehot_to_idx(MAX_N'(win_oh_o)));
      any_o     = |req_i;
   end

endmodule

// File: rtl/ring_rr_arbiter.sv
// rtl/ring_rr_arbiter.sv - round-robin arbiter with rotating one-hot ring; hold limit under ARB_TIMEOUT_EN
module ring_rr_arbiter
   import ring_arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         done,
   output logic [N-1:0]         grant,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 timeout
);

   localparam int IW = $clog2(N);

   arb_state_e    state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [IW-1:0] id_q, id_d;
   logic [N-1:0]  ptr_q, ptr_d;

   logic [N-1:0]  win_oh;
   logic [IW-1:0] win_idx;
   logic          win_any;
   logic          release_req;
   logic          expire;

`ifdef ARB_TIMEOUT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] hold_q, hold_d;
   logic          timeout_q, timeout_d;
`else
   logic [31:0]   unused_max_hold;
   assign unused_max_hold = MAX_HOLD;
`endif

   rr_ring_pick #(.N(N), .IW(IW)) u_pick (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .win_oh_o  (win_oh),
      .win_idx_o (win_idx),
      .any_o     (win_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         id_q      <= '0;
         ptr_q     <= N'(1);
`ifdef ARB_TIMEOUT_EN
         hold_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         id_q      <= id_d;
         ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   // Owner is identified through grant_q itself, so non-owner done bits never matter.
   always_comb begin
      release_req = (|(done & grant_q)) | ~(|(req & grant_q));
`ifdef ARB_TIMEOUT_EN
      expire      = (hold_q == HW'(MAX_HOLD));
`else
      expire      = 1'b0;
`endif
      state_d = state_q;
      grant_d = grant_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (win_any) begin
               state_d = BUSY;
               grant_d = win_oh;
               id_d    = win_idx;
`ifdef ARB_TIMEOUT_EN
               hold_d  = HW'(1);
`endif
            end
         end
         BUSY: begin
            if (release_req || expire) begin
               state_d = GAP;
               grant_d = '0;
               id_d    = '0;
               ptr_d   = N'(rotl1(MAX_N'(grant_q), N));
`ifdef ARB_TIMEOUT_EN
               timeout_d = expire && !release_req;
`endif
            end else begin
`ifdef ARB_TIMEOUT_EN
               if (hold_q != HW'(MAX_HOLD)) hold_d = hold_q + HW'(1);
`endif
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant       = grant_q;
      grant_valid = |grant_q;
      grant_id    = id_q;
`ifdef ARB_TIMEOUT_EN
      timeout     = timeout_q;
`else
      timeout     = 1'b0;
`endif
   end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb/tb_ring_rr_arbiter.sv - vector table plus hand sequences, checked through an expectation queue
module tb_ring_rr_arbiter;

   localparam int N  = 4;
   localparam int NV = 33;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] done;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic [1:0]   grant_id;
   logic         timeout;

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] done;
      logic [3:0] g;
   } vec_t;

   typedef struct packed {
      logic [3:0] g;
      logic       v;
      logic [1:0] id;
      logic       to;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[NV];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ring_rr_arbiter #(.N(N), .MAX_HOLD(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .timeout     (timeout)
   );

   function automatic logic [1:0] oh2i(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                       input logic to, input string tag);
      exp_t e;
      req  = r;
      done = d;
      e.g  = g;
      e.v  = |g;
      e.id = oh2i(g);
      e.to = to;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({tag, ".grant"},   32'(grant),       32'(e.g));
         check({tag, ".valid"},   32'(grant_valid), 32'(e.v));
         check({tag, ".id"},      32'(grant_id),    32'(e.id));
         check({tag, ".timeout"}, 32'(timeout),     32'(e.to));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs = '{
         '{4'b0101, 4'b0000, 4'b0001}, '{4'b0101, 4'b0001, 4'b0000},
         '{4'b0101, 4'b0000, 4'b0000}, '{4'b0101, 4'b0000, 4'b0100},
         '{4'b0101, 4'b0100, 4'b0000}, '{4'b0000, 4'b0000, 4'b0000},
         '{4'b0000, 4'b0000, 4'b0000}, '{4'b1111, 4'b0000, 4'b1000},
         '{4'b1111, 4'b0000, 4'b1000}, '{4'b1111, 4'b1000, 4'b0000},
         '{4'b1111, 4'b0000, 4'b0000}, '{4'b1111, 4'b0000, 4'b0001},
         '{4'b1111, 4'b0000, 4'b0001}, '{4'b1111, 4'b0001, 4'b0000},
         '{4'b1111, 4'b0000, 4'b0000}, '{4'b1111, 4'b0000, 4'b0010},
         '{4'b1111, 4'b0000, 4'b0010}, '{4'b1111, 4'b0010, 4'b0000},
         '{4'b1111, 4'b0000, 4'b0000}, '{4'b1111, 4'b0000, 4'b0100},
         '{4'b1111, 4'b0000, 4'b0100}, '{4'b1111, 4'b0100, 4'b0000},
         '{4'b1111, 4'b0000, 4'b0000}, '{4'b1111, 4'b0000, 4'b1000},
         '{4'b1111, 4'b0000, 4'b1000}, '{4'b1111, 4'b1000, 4'b0000},
         '{4'b1111, 4'b0000, 4'b0000}, '{4'b1111, 4'b0000, 4'b0001},
         '{4'b1111, 4'b0100, 4'b0001}, '{4'b1111, 4'b0000, 4'b0001},
         '{4'b1110, 4'b0000, 4'b0000}, '{4'b0000, 4'b0000, 4'b0000},
         '{4'b0000, 4'b0000, 4'b0000}
      };

      rst  = 1'b1;
      req  = '0;
      done = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.grant",   32'(grant),       32'd0);
      check("reset.valid",   32'(grant_valid), 32'd0);
      check("reset.id",      32'(grant_id),    32'd0);
      check("reset.timeout", 32'(timeout),     32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++)
         step(vecs[i].req, vecs[i].done, vecs[i].g, 1'b0, $sformatf("vec%0d", i));

      // Single requester held with done never asserted.
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 8; i++) step(4'b1000, 4'b0000, 4'b1000, 1'b0, $sformatf("hold%0d", i));
      step(4'b1000, 4'b0000, 4'b0000, 1'b1, "expire_gap");
      step(4'b1000, 4'b0000, 4'b0000, 1'b0, "expire_idle");
      for (int i = 0; i < 8; i++) step(4'b1000, 4'b0000, 4'b1000, 1'b0, $sformatf("rehold%0d", i));
      step(4'b1000, 4'b1000, 4'b0000, 1'b0, "done_and_expire");
`else
      for (int i = 0; i < 60; i++) step(4'b1000, 4'b0000, 4'b1000, 1'b0, $sformatf("hold%0d", i));
      step(4'b1000, 4'b1000, 4'b0000, 1'b0, "hold_release");
`endif
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, "post_hold_gap");

      // Move ptr away from bit 0 so the reset of ptr is observable.
      step(4'b0100, 4'b0000, 4'b0100, 1'b0, "pre_rst_a");
      step(4'b0100, 4'b0100, 4'b0000, 1'b0, "pre_rst_b");
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, "pre_rst_c");
      step(4'b0100, 4'b0000, 4'b0100, 1'b0, "pre_rst_d");

      #3;
      rst = 1'b1;
      #1;
      check("async_rst.grant", 32'(grant),       32'd0);
      check("async_rst.valid", 32'(grant_valid), 32'd0);
      check("async_rst.id",    32'(grant_id),    32'd0);
      @(negedge clk);
      req  = 4'b1111;
      done = 4'b0000;
      @(posedge clk);
      #1;
      check("in_rst.grant", 32'(grant), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("after_rst.grant", 32'(grant),    32'b0001);
      check("after_rst.id",    32'(grant_id), 32'd0);
      check("after_rst.valid", 32'(grant_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
